// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the cacheline adaptor, bundled together.
// The slave modport is the adaptor's view; master is the view of the cache and memory around it.
interface cacheline_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
);
  logic [31:0]            address_i;
  logic                   read_i;
  logic                   write_i;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic                   resp_o;
  logic [31:0]            address_o;
  logic                   read_o;
  logic                   write_o;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic                   resp_i;

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts whole cache-line reads/writes into BEATS-long memory bursts.
// One request is serviced at a time, and each line ends with a one-cycle resp_o pulse.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adaptor_if.slave bus
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 state_reg;
  logic [KW-1:0]          k_reg;
  logic [KW-1:0]          k_next;
  logic [BURST_WIDTH-1:0] wbuf_reg [BEATS];
  logic [31:0]            address_reg;
  logic [BURST_WIDTH-1:0] burst_reg;
  logic                   read_reg;
  logic                   write_reg;
  logic                   resp_reg;
  logic                   unused_addr_bits;

  assign k_next           = (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
  assign unused_addr_bits = ^bus.address_i[4:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      address_reg <= '0;
      burst_reg   <= '0;
      read_reg    <= 1'b0;
      write_reg   <= 1'b0;
      resp_reg    <= 1'b0;
      for (int i = 0; i < BEATS; i++) wbuf_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            address_reg <= {bus.address_i[31:5], 5'b0};
            k_reg       <= '0;
          end
          // Writes win over reads when the cache raises both.
          if (bus.write_i) begin
            state_reg <= WRITE;
            write_reg <= 1'b1;
            burst_reg <= bus.line_i[BURST_WIDTH-1:0];
            for (int i = 0; i < BEATS; i++)
              wbuf_reg[i] <= bus.line_i[i*BURST_WIDTH +: BURST_WIDTH];
          end else if (bus.read_i) begin
            state_reg <= READ;
            read_reg  <= 1'b1;
          end
        end
        READ, WRITE: begin
          if (bus.resp_i) begin
            k_reg <= k_next;
            if (state_reg == WRITE) burst_reg <= wbuf_reg[k_next];
            if (k_reg == K_LAST) begin
              state_reg <= DONE;
              read_reg  <= 1'b0;
              write_reg <= 1'b0;
              resp_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          resp_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Each read beat lands in its own lane; lanes hold until the next read overwrites them.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      logic [BURST_WIDTH-1:0] lane_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          lane_reg <= '0;
        else if (state_reg == READ && bus.resp_i && k_reg == KW'(gi))
          lane_reg <= bus.burst_i;
      end
      assign bus.line_o[gi*BURST_WIDTH +: BURST_WIDTH] = lane_reg;
    end
  endgenerate

  assign bus.address_o = address_reg;
  assign bus.read_o    = read_reg;
  assign bus.write_o   = write_reg;
  assign bus.resp_o    = resp_reg;
  assign bus.burst_o   = burst_reg;
endmodule
